block_unstacker: RTL and testbench

//  Downstream counterpart of the word-to-block stacker on the AES output path.

---
 rtl/block_unstacker_pkg.sv | 9 +
 rtl/block_unstacker_if.sv | 28 ++
 rtl/block_unstacker_block_buffer.sv | 57 +++++
 rtl/block_unstacker.sv | 82 ++++++++
 tb/tb_block_unstacker.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/block_unstacker_pkg.sv
// Widths and types shared along the AES output streaming path.
package aes_stream_pkg;
   localparam int BLOCK_W = 128;
   localparam int WORD_W  = 32;
   localparam int NWORDS  = BLOCK_W / WORD_W;

   typedef logic [BLOCK_W-1:0] block_t;
   typedef logic [WORD_W-1:0]  word_t;
endpackage

// File: rtl/block_unstacker_if.sv
// Block-in / word-out stream bundle between the cipher core, the unstacker and the HWPE stream.
interface block_unstacker_if #(
   parameter int BLOCK_W = aes_stream_pkg::BLOCK_W,
   parameter int WORD_W  = aes_stream_pkg::WORD_W,
   parameter int OCC_W   = 2
);
   // Both sides use strict valid/ready: a transfer happens on a cycle where
   // valid and ready are both high; valid never waits for ready, and data is
   // held stable while valid is high and ready is low.
   logic               valid_i;
   logic               ready_o;
   logic [BLOCK_W-1:0] block_i;
   logic               valid_o;
   logic               ready_i;
   logic [WORD_W-1:0]  word_o;
   logic               last_o;
   logic [OCC_W-1:0]   occupancy_o;

   modport slave (
      input  valid_i, block_i, ready_i,
      output ready_o, valid_o, word_o, last_o, occupancy_o
   );

   modport master (
      output valid_i, block_i, ready_i,
      input  ready_o, valid_o, word_o, last_o, occupancy_o
   );
endinterface

// File: rtl/block_unstacker_block_buffer.sv
// DEPTH-entry block FIFO; the head entry stays visible on dout until popped.
module block_buffer #(
   parameter int BLOCK_W = 128,
   parameter int DEPTH   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         enable,
   input  logic                         push,
   input  logic                         pop,
   input  logic [BLOCK_W-1:0]           din,
   output logic [BLOCK_W-1:0]           dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [BLOCK_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (enable) begin
         if (push) wr_ptr <= wrap_inc(wr_ptr);
         if (pop)  rd_ptr <= wrap_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is never cleared; the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (!rst && !clr && enable && push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (!rst) assert (count <= CNT_W'(DEPTH));
   end
endmodule

// File: rtl/block_unstacker.sv
// Buffers 128-bit cipher blocks and serialises each into words, most significant word first.
module block_unstacker
   import aes_stream_pkg::*;
#(
   parameter int BLOCK_W = aes_stream_pkg::BLOCK_W,
   parameter int WORD_W  = aes_stream_pkg::WORD_W,
   parameter int DEPTH   = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          enable_i,
   block_unstacker_if.slave bus
);
   localparam int WORDS  = BLOCK_W / WORD_W;
   localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int OCC_W  = $clog2(DEPTH+1);

   if (BLOCK_W % WORD_W != 0) begin : g_bad_width
      $error("block_unstacker: BLOCK_W must be a multiple of WORD_W");
   end
   if (DEPTH < 1) begin : g_bad_depth
      $error("block_unstacker: DEPTH must be at least 1");
   end

   logic [WCNT_W-1:0]  word_cnt;
   logic [BLOCK_W-1:0] head;
   logic [WORD_W-1:0]  head_words [WORDS];
   logic [OCC_W-1:0]   count;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop_word;
   logic               pop_block;
   logic               word_last;

   // ready_o looks only at registered state (plus reset), never at ready_i,
   // so a full buffer cannot accept on the same cycle its head block drains.
   assign bus.ready_o = ~rst_i & enable_i & ~full;
   assign bus.valid_o = enable_i & ~empty;

   assign push      = bus.valid_i & bus.ready_o;
   assign pop_word  = bus.valid_o & bus.ready_i;
   assign word_last = (word_cnt == WCNT_W'(WORDS-1));
   assign pop_block = pop_word & word_last;

   block_buffer #(
      .BLOCK_W (BLOCK_W),
      .DEPTH   (DEPTH)
   ) u_buffer (
      .clk    (clk_i),
      .rst    (rst_i),
      .clr    (clr_i),
      .enable (enable_i),
      .push   (push),
      .pop    (pop_block),
      .din    (bus.block_i),
      .dout   (head),
      .full   (full),
      .empty  (empty),
      .count  (count)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         word_cnt <= '0;
      end else if (enable_i && pop_word) begin
         word_cnt <= word_last ? '0 : word_cnt + WCNT_W'(1);
      end
   end

   // Word 0 is the most significant slice of the block.
   always_comb begin
      for (int i = 0; i < WORDS; i++) begin
         head_words[i] = head[BLOCK_W-1-i*WORD_W -: WORD_W];
      end
   end

   assign bus.word_o      = bus.valid_o ? head_words[word_cnt] : '0;
   assign bus.last_o      = bus.valid_o & word_last;
   assign bus.occupancy_o = count;
endmodule

// File: tb/tb_block_unstacker.sv
// Directed scoreboard bench for block_unstacker: driver pushes expected words, monitor pops and compares.
module tb_block_unstacker;
   import aes_stream_pkg::*;

   localparam int DEPTH = 2;
   localparam int OCC_W = $clog2(DEPTH+1);

   logic clk = 1'b0;
   logic rst;
   logic clr;
   logic enable;

   block_unstacker_if #(.BLOCK_W(BLOCK_W), .WORD_W(WORD_W), .OCC_W(OCC_W)) bus ();

   block_unstacker #(.BLOCK_W(BLOCK_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .clr_i    (clr),
      .enable_i (enable),
      .bus      (bus)
   );

   // ---------------- clock / reset / bookkeeping ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   logic [WORD_W:0] exp_q[$];
   int              pop_cyc_q[$];
   int              last_cyc_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_exp(input logic [BLOCK_W-1:0] b);
      for (int i = 0; i < NWORDS; i++) begin
         exp_q.push_back({(i == NWORDS-1), b[BLOCK_W-1-i*WORD_W -: WORD_W]});
      end
   endtask

   task automatic send(input logic [BLOCK_W-1:0] b, output int acc_cyc);
      int n = 0;
      bus.valid_i = 1'b1;
      bus.block_i = b;
      @(negedge clk);
      while (!bus.ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.ready_o) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: ready_o got 0, expected 1 within 200 cycles");
         acc_cyc = -1;
      end else begin
         acc_cyc = cyc;
         push_exp(b);
      end
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic            stall_prev = 1'b0;
   logic [WORD_W:0] held;
   logic [WORD_W:0] e;

   always @(negedge clk) begin
      if (stall_prev && bus.valid_o)
         check("stall_stable", {bus.last_o, bus.word_o}, held);
      if (!bus.valid_o)
         check("idle_outputs_zero", {bus.last_o, bus.word_o}, '0);
      if (bus.valid_o && bus.ready_i && !rst && !clr) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got %0h, expected no word", {bus.last_o, bus.word_o});
         end else begin
            e = exp_q.pop_front();
            check("word_last", {bus.last_o, bus.word_o}, e);
         end
         pop_cyc_q.push_back(cyc);
         if (bus.last_o) last_cyc_q.push_back(cyc);
      end
      stall_prev = bus.valid_o && !bus.ready_i && !rst && !clr;
      held       = {bus.last_o, bus.word_o};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   localparam logic [127:0] B0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] B1 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
   localparam logic [127:0] B2 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
   localparam logic [127:0] B3 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

   int a0, a1, a2;

   initial begin
      rst = 1'b1; clr = 1'b0; enable = 1'b1;
      bus.valid_i = 1'b0; bus.ready_i = 1'b1; bus.block_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", bus.ready_o, 0);
      check("rst_valid", bus.valid_o, 0);
      check("rst_word", bus.word_o, 0);
      check("rst_last", bus.last_o, 0);
      check("rst_occ", bus.occupancy_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", bus.ready_o, 1);
      @(posedge clk); #1;

      // 1: single block, word 0 one cycle after acceptance
      pop_cyc_q.delete();
      send(B0, a0);
      drain();
      check("t1_pops", pop_cyc_q.size(), 4);
      if (pop_cyc_q.size() == 4) begin
         check("t1_first_latency", pop_cyc_q[0], a0 + 1);
         check("t1_last_cycle", pop_cyc_q[3], a0 + 4);
      end

      // 2: three blocks back-to-back
      pop_cyc_q.delete();
      last_cyc_q.delete();
      send(B0, a0);
      send(B1, a1);
      send(B2, a2);
      drain();
      check("t2_pops", pop_cyc_q.size(), 12);
      if (pop_cyc_q.size() == 12) check("t2_no_bubbles", pop_cyc_q[11] - pop_cyc_q[0], 11);
      check("t2_b1_accept", a1, a0 + 1);
      if (last_cyc_q.size() != 0) check("t2_b2_accept", a2, last_cyc_q[0] + 1);

      // 3: fill with ready_i low, third block waits for a freed entry
      bus.ready_i = 1'b0;
      send(B1, a0);
      send(B3, a1);
      @(negedge clk);
      check("t3_occ_full", bus.occupancy_o, 2);
      check("t3_ready_full", bus.ready_o, 0);
      bus.valid_i = 1'b1;
      bus.block_i = B2;
      @(posedge clk); #1;
      @(negedge clk);
      check("t3_ready_held", bus.ready_o, 0);
      @(posedge clk); #1;
      bus.ready_i = 1'b1;
      last_cyc_q.delete();
      send(B2, a2);
      if (last_cyc_q.size() != 0) check("t3_b2_accept", a2, last_cyc_q[0] + 1);
      drain();

      // 4: ready_i toggling every cycle
      fork
         begin
            send(B3, a0);
            send(B0, a1);
         end
         begin
            repeat (24) begin
               @(posedge clk); #1;
               bus.ready_i = ~bus.ready_i;
            end
         end
      join
      bus.ready_i = 1'b1;
      drain();

      // 5: clear after two words
      send(B1, a0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      check("t5_valid", bus.valid_o, 0);
      check("t5_occ", bus.occupancy_o, 0);
      check("t5_ready", bus.ready_o, 1);
      @(posedge clk); #1;
      send(B2, a0);
      drain();

      // 6: enable low for three cycles mid-block, then reset mid-block
      send(B3, a0);
      @(posedge clk); #1;
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_dis_valid", bus.valid_o, 0);
         check("t6_dis_ready", bus.ready_o, 0);
         @(posedge clk); #1;
      end
      enable = 1'b1;
      @(posedge clk); #1;
      check("t6_resume_pending", exp_q.size(), 2);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("t6_rst_ready", bus.ready_o, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t6_rst_valid", bus.valid_o, 0);
      check("t6_rst_word", bus.word_o, 0);
      check("t6_rst_last", bus.last_o, 0);
      check("t6_rst_occ", bus.occupancy_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_post_ready", bus.ready_o, 1);
      check("t6_post_valid", bus.valid_o, 0);
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
